// File: rtl/filter_sched_pkg.sv
// Shared types and constants for the filter scheduler: FSM state encoding,
// sample width and default filter latency.
package filter_sched_pkg;

  localparam int SAMPLE_W    = 4;
  localparam int LAT_DEFAULT = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

endpackage

// File: rtl/filter_sched_rr_arb2.sv
// Two-way round-robin arbiter: a lone requester wins, on contention the
// requester that was not granted last wins. Grant is one-hot or zero.
module rr_arb2 (
  input  logic [1:0] req,
  input  logic       last_grant,
  input  logic       enable,
  output logic [1:0] grant
);

  always_comb begin
    grant = 2'b00;
    if (enable) begin
      if (req == 2'b11) grant = last_grant ? 2'b01 : 2'b10;
      else              grant = req;
    end
  end

endmodule

// File: rtl/filter_sched.sv
// Schedules two requesters onto one shared filter unit, one operation in
// flight at a time: grant, strobe the sample, wait LAT cycles, capture, ack.
module filter_sched
  import filter_sched_pkg::*;
#(
  parameter int LAT  = LAT_DEFAULT,
  parameter int CNTW = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                req0,
  input  logic [SAMPLE_W-1:0] x0,
  output logic                ack0,
  output logic                res0,
  input  logic                req1,
  input  logic [SAMPLE_W-1:0] x1,
  output logic                ack1,
  output logic                res1,
  output logic [SAMPLE_W-1:0] f_x,
  output logic                f_x_is_valid,
  input  logic                f_y,
  output logic                busy,
  output logic [CNTW-1:0]     done_cnt
);

  state_t              r_state, w_state_nxt;
  logic [SAMPLE_W-1:0] r_sample;
  logic [3:0]          r_wcnt;
  logic                r_last;     // last granted requester, also owner of the op in flight
  logic                r_res0, r_res1;
  logic [CNTW-1:0]     r_done;
  logic [1:0]          w_gnt;

  rr_arb2 u_arb (
    .req        ({req1, req0}),
    .last_grant (r_last),
    .enable     (r_state == IDLE),
    .grant      (w_gnt)
  );

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (|w_gnt) w_state_nxt = ISSUE;
      ISSUE:   w_state_nxt = WAIT;
      WAIT:    if (r_wcnt == 4'd0) w_state_nxt = RESP;
      RESP:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= IDLE;
      r_sample <= '0;
      r_wcnt   <= 4'd0;
      r_last   <= 1'b1;
      r_res0   <= 1'b0;
      r_res1   <= 1'b0;
      r_done   <= '0;
    end else begin
      r_state <= w_state_nxt;
      case (r_state)
        IDLE: if (|w_gnt) begin
          r_sample <= w_gnt[1] ? x1 : x0;
          r_last   <= w_gnt[1];
        end
        ISSUE: r_wcnt <= 4'(LAT - 1);
        WAIT: begin
          // f_y is only trusted on the final wait edge
          if (r_wcnt == 4'd0) begin
            if (r_last) r_res1 <= f_y;
            else        r_res0 <= f_y;
          end else begin
            r_wcnt <= r_wcnt - 4'd1;
          end
        end
        RESP: r_done <= r_done + CNTW'(1);
        default: ;
      endcase
    end
  end

  assign f_x          = r_sample;
  assign f_x_is_valid = (r_state == ISSUE);
  assign ack0         = (r_state == RESP) && !r_last;
  assign ack1         = (r_state == RESP) &&  r_last;
  assign res0         = r_res0;
  assign res1         = r_res1;
  assign busy         = (r_state != IDLE);
  assign done_cnt     = r_done;

endmodule
